// File: rtl/register_file_sb.sv
// Two-read/one-write register file with registered reads, optional write bypass,
// optional hardwired-zero R0 and a per-register pending (scoreboard) bit with a running count.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  BUSY_R1,
    output logic                  BUSY_R2,
    output logic                  RD_VALID,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  RESERVE,
    input  logic [ADDR_WIDTH-1:0] ADDR_RES,
    output logic [ADDR_WIDTH:0]   PEND_CNT
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_next;
    logic                  wr_eff;
    logic                  res_eff;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [DATA_WIDTH-1:0] rd1_data;
    logic [DATA_WIDTH-1:0] rd2_data;
    logic                  rd1_busy;
    logic                  rd2_busy;

    // Writes and reservations aimed at a hardwired R0 are dropped before touching any state.
    always_comb begin
        wr_eff  = WRITE && !(ZERO_REG && (ADDR_W == '0));
        res_eff = RESERVE && !(ZERO_REG && (ADDR_RES == '0));

        pend_next = pend;
        if (wr_eff)
            pend_next[ADDR_W] = 1'b0;
        if (res_eff)
            pend_next[ADDR_RES] = 1'b1;

        // A write clearing a bit that is re-reserved this edge does not count as a release.
        cnt_inc = res_eff && !pend[ADDR_RES];
        cnt_dec = wr_eff && pend[ADDR_W] && !(res_eff && (ADDR_RES == ADDR_W));
    end

    always_comb begin
        rd1_data = regs[ADDR_R1];
        rd2_data = regs[ADDR_R2];
        if (BYPASS && wr_eff && (ADDR_W == ADDR_R1))
            rd1_data = DATA_W;
        if (BYPASS && wr_eff && (ADDR_W == ADDR_R2))
            rd2_data = DATA_W;

        rd1_busy = BYPASS ? pend_next[ADDR_R1] : pend[ADDR_R1];
        rd2_busy = BYPASS ? pend_next[ADDR_R2] : pend[ADDR_R2];

        if (ZERO_REG && (ADDR_R1 == '0)) begin
            rd1_data = '0;
            rd1_busy = 1'b0;
        end
        if (ZERO_REG && (ADDR_R2 == '0)) begin
            rd2_data = '0;
            rd2_busy = 1'b0;
        end
    end

    // RD_VALID is a one-cycle qualifier with no back-pressure: it is high for exactly the
    // cycle after an edge that sampled READ=1, and DATA_R*/BUSY_R* are meaningful while it is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pend     <= '0;
            PEND_CNT <= '0;
            DATA_R1  <= '0;
            DATA_R2  <= '0;
            BUSY_R1  <= 1'b0;
            BUSY_R2  <= 1'b0;
            RD_VALID <= 1'b0;
        end else begin
            if (wr_eff)
                regs[ADDR_W] <= DATA_W;
            pend <= pend_next;

            if (cnt_inc && !cnt_dec && (PEND_CNT != CNT_MAX))
                PEND_CNT <= PEND_CNT + 1'b1;
            else if (cnt_dec && !cnt_inc && (PEND_CNT != '0))
                PEND_CNT <= PEND_CNT - 1'b1;

            RD_VALID <= READ;
            if (READ) begin
                DATA_R1 <= rd1_data;
                DATA_R2 <= rd2_data;
                BUSY_R1 <= rd1_busy;
                BUSY_R2 <= rd2_busy;
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: one bypassing and one non-bypassing instance
// share stimulus; each has its own expected-read queue drained by a monitor on RD_VALID.
module tb_register_file_sb;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic        write;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        reserve;
    logic [4:0]  addr_res;

    logic [31:0] data_r1_b, data_r2_b, data_r1_n, data_r2_n;
    logic        busy_r1_b, busy_r2_b, busy_r1_n, busy_r2_n;
    logic        rd_valid_b, rd_valid_n;
    logic [5:0]  pend_cnt_b, pend_cnt_n;

    logic [65:0] exp_b_q[$];
    logic [65:0] exp_n_q[$];

    int n_chk;
    int n_fail;

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .CLK(clk), .RST(rst_n), .READ(read), .ADDR_R1(addr_r1), .ADDR_R2(addr_r2),
        .DATA_R1(data_r1_b), .DATA_R2(data_r2_b), .BUSY_R1(busy_r1_b), .BUSY_R2(busy_r2_b),
        .RD_VALID(rd_valid_b), .WRITE(write), .ADDR_W(addr_w), .DATA_W(data_w),
        .RESERVE(reserve), .ADDR_RES(addr_res), .PEND_CNT(pend_cnt_b)
    );

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .CLK(clk), .RST(rst_n), .READ(read), .ADDR_R1(addr_r1), .ADDR_R2(addr_r2),
        .DATA_R1(data_r1_n), .DATA_R2(data_r2_n), .BUSY_R1(busy_r1_n), .BUSY_R2(busy_r2_n),
        .RD_VALID(rd_valid_n), .WRITE(write), .ADDR_W(addr_w), .DATA_W(data_w),
        .RESERVE(reserve), .ADDR_RES(addr_res), .PEND_CNT(pend_cnt_n)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, the transaction lands on the next rising edge.
    task automatic drive(input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                         input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                         input logic rs, input logic [4:0] ar);
        @(negedge clk);
        read = rd; addr_r1 = a1; addr_r2 = a2;
        write = wr; addr_w = aw; data_w = dw;
        reserve = rs; addr_res = ar;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0; reserve = 1'b0;
    endtask

    task automatic expect_rd(input logic [31:0] d1, input logic [31:0] d2, input logic b1, input logic b2,
                             input logic [31:0] d1n, input logic [31:0] d2n, input logic b1n, input logic b2n);
        exp_b_q.push_back({d1, d2, b1, b2});
        exp_n_q.push_back({d1n, d2n, b1n, b2n});
    endtask

    task automatic expect_same(input logic [31:0] d1, input logic [31:0] d2, input logic b1, input logic b2);
        expect_rd(d1, d2, b1, b2, d1, d2, b1, b2);
    endtask

    task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b1, a1, a2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic check_cnt(input string name, input logic [5:0] exp);
        check({name, "_b"}, 66'(pend_cnt_b), 66'(exp));
        check({name, "_n"}, 66'(pend_cnt_n), 66'(exp));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_out_b"}, {data_r1_b, data_r2_b, busy_r1_b, busy_r2_b}, 66'd0);
        check({name, "_out_n"}, {data_r1_n, data_r2_n, busy_r1_n, busy_r2_n}, 66'd0);
        check({name, "_valid"}, {64'd0, rd_valid_b, rd_valid_n}, 66'd0);
        check_cnt({name, "_cnt"}, 6'd0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && rd_valid_b) begin
            if (exp_b_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_b: got %h with no read outstanding, required no RD_VALID",
                         {data_r1_b, data_r2_b, busy_r1_b, busy_r2_b});
            end else begin
                check("rd_b", {data_r1_b, data_r2_b, busy_r1_b, busy_r2_b}, exp_b_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid_n) begin
            if (exp_n_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_n: got %h with no read outstanding, required no RD_VALID",
                         {data_r1_n, data_r2_n, busy_r1_n, busy_r2_n});
            end else begin
                check("rd_n", {data_r1_n, data_r2_n, busy_r1_n, busy_r2_n}, exp_n_q.pop_front());
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        read = 1'b0; addr_r1 = '0; addr_r2 = '0;
        write = 1'b0; addr_w = '0; data_w = '0;
        reserve = 1'b0; addr_res = '0;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Read of R0 and R31 straight out of reset
        expect_same(32'd0, 32'd0, 1'b0, 1'b0);
        read_pair(5'd0, 5'd31);
        check_cnt("cnt_after_reset", 6'd0);

        // Fill R1..R31 with their index, then read i and 32-i
        for (int i = 1; i < 32; i++)
            drive(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            expect_same(32'(i), 32'(32 - i), 1'b0, 1'b0);
            read_pair(5'(i), 5'(32 - i));
        end

        // Write to hardwired R0 is dropped
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0);
        expect_same(32'd0, 32'd0, 1'b0, 1'b0);
        read_pair(5'd0, 5'd0);

        // Same-edge read-after-write: bypass sees new value, non-bypass sees old R5
        expect_rd(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0);
        expect_same(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);
        read_pair(5'd5, 5'd5);

        // Reservations: 3, 7, 7 leaves two pending
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        check_cnt("cnt_res_3_7_7", 6'd2);
        expect_same(32'd3, 32'd7, 1'b1, 1'b1);
        read_pair(5'd3, 5'd7);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        check_cnt("cnt_wr_3", 6'd1);
        expect_same(32'h33, 32'd7, 1'b0, 1'b1);
        read_pair(5'd3, 5'd7);

        // Write and reserve R9 together: new producer wins, count +1
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
        check_cnt("cnt_wr_res_9", 6'd2);
        expect_same(32'h99, 32'h99, 1'b1, 1'b1);
        read_pair(5'd9, 5'd9);

        // Reserve R4 while writing pending R9: net count change is zero
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd4);
        check_cnt("cnt_res4_wr9", 6'd2);
        expect_same(32'd4, 32'h999, 1'b1, 1'b0);
        read_pair(5'd4, 5'd9);

        // Same-edge write of pending R7: bypass sees new data and cleared busy
        expect_rd(32'h77, 32'd4, 1'b0, 1'b1, 32'd7, 32'd4, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 5'd4, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        check_cnt("cnt_wr_7", 6'd1);

        // Same-edge reserve of R12: bypass sees the new pending bit
        expect_rd(32'd12, 32'd12, 1'b1, 1'b1, 32'd12, 32'd12, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 5'd12, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        check_cnt("cnt_res_12", 6'd2);

        // Reserving R0 is ignored
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        check_cnt("cnt_res_0", 6'd2);

        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21);
        check_cnt("cnt_four_pending", 6'd4);

        // Asynchronous reset between edges while a read result is being presented
        expect_same(32'd20, 32'd21, 1'b1, 1'b1);
        read_pair(5'd20, 5'd21);
        check({"pre_reset_valid"}, {64'd0, rd_valid_b, rd_valid_n}, 66'd3);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        // The read being presented is dropped by the reset before its monitor sample
        exp_b_q.delete();
        exp_n_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            expect_same(32'd0, 32'd0, 1'b0, 1'b0);
            read_pair(5'(i), 5'(31 - i));
        end
        check_cnt("cnt_after_rerun", 6'd0);

        repeat (2) @(negedge clk);
        #1;
        check("q_b_drained", 66'(exp_b_q.size()), 66'd0);
        check("q_n_drained", 66'(exp_n_q.size()), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised two-read/one-write register file with registered read ports, optional write-to-read bypass, optional hardwired-zero register 0, and a per-register pending (scoreboard) bit for the pipelined datapath. It is the next-generation replacement for the fixed 32x32 register file. It sits between the decode stage (reads, reservations) and the write-back stage (writes).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1: register 0 reads as 0 and is never written or reserved
- BYPASS, 1, 1: a same-cycle write is forwarded to a read of the same address

- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset
- READ  in  1  read strobe; samples both read ports this edge
- ADDR_R1  in  ADDR_WIDTH  read port 1 address
- ADDR_R2  in  ADDR_WIDTH  read port 2 address
- DATA_R1  out  DATA_WIDTH  registered read data, port 1
- DATA_R2  out  DATA_WIDTH  registered read data, port 2
- BUSY_R1  out  1  registered pending bit of the register read on port 1
- BUSY_R2  out  1  registered pending bit of the register read on port 2
- RD_VALID  out  1  high for one cycle after an edge with READ=1
- WRITE  in  1  write strobe
- ADDR_W  in  ADDR_WIDTH  write address
- DATA_W  in  DATA_WIDTH  write data
- RESERVE  in  1  marks register ADDR_RES pending (result outstanding)
- ADDR_RES  in  ADDR_WIDTH  reservation address
- PEND_CNT  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- Reset (RST=0, asynchronous): all registers, all pending bits, DATA_R1/2, BUSY_R1/2, RD_VALID and PEND_CNT go to 0 immediately and hold while RST=0. Reset mid-read clears RD_VALID the same instant.
- Write: at an edge with WRITE=1, REG[ADDR_W] <= DATA_W and PEND[ADDR_W] <= 0. With ZERO_REG=1 and ADDR_W=0, the write is ignored.
- Reserve: at an edge with RESERVE=1, PEND[ADDR_RES] <= 1. With ZERO_REG=1 and ADDR_RES=0, the reservation is ignored. Reserving an already-pending register is legal and leaves it at 1.
- WRITE and RESERVE to the same address in one cycle: REG is updated and PEND ends at 1, because the new producer wins.
- Read: at an edge with READ=1, each port captures data and busy. RD_VALID <= READ every edge. When READ=0, DATA_R*/BUSY_R* hold their previous values.
- Read data:
  - With BYPASS=1 and a write to the read address this edge (write not suppressed by ZERO_REG), DATA_W is captured.
  - Otherwise the pre-edge REG contents are captured.
  - With ZERO_REG=1, address 0 always returns 0.
- Read busy:
  - With BYPASS=1, the post-edge PEND value is captured (write clear and reserve set applied).
  - With BYPASS=0, the pre-edge PEND value is captured.
  - Address 0 returns 0 when ZERO_REG=1.
- Both ports may read the same address; the results are identical.
- PEND_CNT is a counter, not a popcount. Each edge it adds +1 if a reservation turns a 0 bit to 1, and −1 if an effective write clears a 1 bit that is not re-reserved in the same edge. Both adjustments may apply in one edge (net 0). It never exceeds 2**ADDR_WIDTH and never goes below 0.

## Timing
- Write-to-storage: 1 edge. Read latency: 1 edge (address and READ sampled at edge N; data and RD_VALID valid after edge N until edge N+1).
- Read-after-write:
  - BYPASS=1: same-edge read returns the new data.
  - BYPASS=0: a read at the edge after the write returns the new data.
- Pending bit: set or cleared at the same edge as RESERVE/WRITE. BUSY reflects it per the BYPASS rule above.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then READ with ADDR_R1=0, ADDR_R2=31 -> DATA_R1=DATA_R2=0, BUSY=0, RD_VALID=1 one cycle later, PEND_CNT=0.
- Write R[i]=i for i=1..31, then read i on port 1 and 32−i on port 2 -> values match. With ZERO_REG=1, write 0xDEADBEEF to R0 then read -> 0.
- BYPASS=1: WRITE ADDR_W=5, DATA_W=0xA5A5A5A5 with READ ADDR_R1=5 in the same cycle -> DATA_R1=0xA5A5A5A5. Same stimulus with BYPASS=0 -> old R5 value; reading R5 at the next edge -> 0xA5A5A5A5.
- RESERVE 3, 7, 7 over three cycles -> PEND_CNT=2. Read R7 -> BUSY_R2=1. WRITE R3 -> PEND_CNT=1 and BUSY_R1=0 on a read of R3.
- Same-cycle WRITE and RESERVE on R9 (not pending) -> R9 updated, PEND[9]=1, PEND_CNT +1. Same-cycle RESERVE R4 and WRITE pending R9 -> PEND_CNT unchanged.
- Assert RST=0 mid-sequence, between clock edges, with 4 registers pending and RD_VALID=1 -> all outputs 0 immediately. After release, reads of all addresses return 0 and PEND_CNT=0.
